bios_bus_slave: RTL

Bus-side read port for the boot ROM: decodes the ROM address window on the shared system bus, drives the 11-bit word address into the ROM, byte-swaps the little-endian ROM words to big-endian, and returns single or burst reads with the bus handshake. Sits directly upstream of the ROM (owns its address) and downstream of the bus arbiter/CPU master. All bus outputs are zero whenever the block is not driving, so they can be OR-combined on the bus.

---
 rtl/bios_bus_slave.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bios_bus_slave.sv
`default_nettype none
// ============================================================================
// Module   : bios_bus_slave
// Purpose  : Boot-ROM bus read port; decodes the ROM window and returns
//            byte-swapped single or burst reads.
// Revision : 1.0 - initial release
// ============================================================================
module bios_bus_slave #(
  parameter logic [31:0] BASE_ADDRESS = 32'hF000_0000,
  parameter bit          SWAP_BYTES   = 1'b1
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        beginTransactionIn,
  input  logic        endTransactionIn,
  input  logic        readNotWriteIn,
  input  logic [7:0]  burstSizeIn,
  input  logic [31:0] addressDataIn,
  output logic [10:0] romAddress,
  input  logic [31:0] romData,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busErrorOut
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_END   = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [10:0] r_word_ptr;
  logic [7:0]  r_remaining;
  logic [31:0] r_data;
  logic        r_data_valid;
  logic        r_end;
  logic        w_hit;
  logic        w_load;
  logic        w_issue;
  logic        w_advance;
  logic [31:0] w_rom_word;
  logic [1:0]  w_unused_addr_bits;

  assign w_unused_addr_bits = addressDataIn[1:0];
  assign w_hit = beginTransactionIn && (addressDataIn[31:13] == BASE_ADDRESS[31:13]);

  generate
    if (SWAP_BYTES) begin : g_swap
      assign w_rom_word = {romData[7:0], romData[15:8], romData[23:16], romData[31:24]};
    end else begin : g_pass
      assign w_rom_word = romData;
    end
  endgenerate

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE, S_END: begin
        w_next_state = S_IDLE;
        if (w_hit) begin
          w_load       = readNotWriteIn;
          w_next_state = readNotWriteIn ? S_READ : S_ERROR;
        end
      end
      S_READ: begin
        if (endTransactionIn) begin
          w_next_state = S_IDLE;
        end else if (r_remaining == 8'd0) begin
          w_next_state = S_END;
        end
      end
      S_ERROR: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // An abort suppresses the word fetched in the same cycle.
  assign w_issue   = (r_state == S_READ) && !endTransactionIn;
  // The pointer only advances while more words follow, so it doubles as the
  // held ROM address once the burst finishes or is aborted.
  assign w_advance = w_issue && (r_remaining != 8'd0);

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_word_ptr   <= 11'd0;
      r_remaining  <= 8'd0;
      r_data       <= 32'd0;
      r_data_valid <= 1'b0;
      r_end        <= 1'b0;
    end else begin
      if (w_load) begin
        r_word_ptr  <= addressDataIn[12:2];
        r_remaining <= burstSizeIn;
      end else if (w_advance) begin
        r_word_ptr  <= r_word_ptr + 11'd1;
        r_remaining <= r_remaining - 8'd1;
      end
      r_data_valid <= w_issue;
      r_data       <= w_issue ? w_rom_word : 32'd0;
      r_end        <= (r_state == S_END);
    end
  end

  assign romAddress        = r_word_ptr;
  assign addressDataOut    = r_data;
  assign dataValidOut      = r_data_valid;
  assign busErrorOut       = (r_state == S_ERROR);
  assign endTransactionOut = r_end || (r_state == S_ERROR);

endmodule
`default_nettype wire
